// File: rtl/ysyx_22041752_ex_ms_buf.sv
// EX->MEM pipeline buffer: 2-entry skid FIFO with registered-state allowin and pre-formatted
// memory request fields. Define YSYX_22041752_MISALIGN_CHK_EN to flag and suppress misaligned accesses.
module ysyx_22041752_ex_ms_buf #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned RF_AW = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,

    input  logic             es_to_ms_valid,
    output logic             ms_allowin,
    input  logic [XLEN-1:0]  es_pc,
    input  logic [XLEN-1:0]  es_alu_result,
    input  logic [XLEN-1:0]  es_mem_addr,
    input  logic [XLEN-1:0]  es_st_data,
    input  logic             es_rf_we,
    input  logic [RF_AW-1:0] es_rf_waddr,
    input  logic             es_mem_re,
    input  logic             es_mem_we,
    input  logic [1:0]       es_mem_size,
    input  logic             es_ld_uns,

    output logic             ms_valid,
    input  logic             ms_ready,
    output logic [XLEN-1:0]  ms_pc,
    output logic [XLEN-1:0]  ms_alu_result,
    output logic [XLEN-1:0]  ms_addr,
    output logic [2:0]       ms_byte_off,
    output logic [7:0]       ms_wstrb,
    output logic [XLEN-1:0]  ms_wdata,
    output logic             ms_rf_we,
    output logic [RF_AW-1:0] ms_rf_waddr,
    output logic             ms_mem_re,
    output logic             ms_mem_we,
    output logic [1:0]       ms_mem_size,
    output logic             ms_ld_uns,
    output logic             ms_misalign
);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  mem_addr;
        logic [XLEN-1:0]  st_data;
        logic             rf_we;
        logic [RF_AW-1:0] rf_waddr;
        logic             mem_re;
        logic             mem_we;
        logic [1:0]       mem_size;
        logic             ld_uns;
    } entry_t;

    entry_t head_q, head_d, skid_q, skid_d, in_entry;
    logic   head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
    logic   acc;

    assign in_entry = '{
        pc:         es_pc,
        alu_result: es_alu_result,
        mem_addr:   es_mem_addr,
        st_data:    es_st_data,
        rf_we:      es_rf_we,
        rf_waddr:   es_rf_waddr,
        mem_re:     es_mem_re,
        mem_we:     es_mem_we,
        mem_size:   es_mem_size,
        ld_uns:     es_ld_uns
    };

    // Allowin depends only on stored state so EX never sees a path from ms_ready.
    assign ms_allowin = ~skid_valid_q;
    assign acc        = es_to_ms_valid & ms_allowin & ~flush;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!head_valid_q || ms_ready) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                head_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (acc) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    logic [2:0] off;
    logic [7:0] wstrb_raw;
    logic       suppress;

    assign off = head_q.mem_addr[2:0];

`ifdef YSYX_22041752_MISALIGN_CHK_EN
    logic mis;
    always_comb begin
        mis = 1'b0;
        unique case (head_q.mem_size)
            2'd0: mis = 1'b0;
            2'd1: mis = off[0];
            2'd2: mis = (off[1:0] != 2'b00);
            2'd3: mis = (off != 3'b000);
        endcase
    end
    assign ms_misalign = head_valid_q & (head_q.mem_re | head_q.mem_we) & mis;
    assign suppress    = ms_misalign;
`else
    assign ms_misalign = 1'b0;
    assign suppress    = 1'b0;
`endif

    always_comb begin
        wstrb_raw = 8'h00;
        ms_wdata  = head_q.st_data;
        unique case (head_q.mem_size)
            2'd0: begin
                wstrb_raw = 8'h01 << off;
                ms_wdata  = {(XLEN/8){head_q.st_data[7:0]}};
            end
            2'd1: begin
                wstrb_raw = 8'h03 << {off[2:1], 1'b0};
                ms_wdata  = {(XLEN/16){head_q.st_data[15:0]}};
            end
            2'd2: begin
                wstrb_raw = 8'h0F << {off[2], 2'b00};
                ms_wdata  = {(XLEN/32){head_q.st_data[31:0]}};
            end
            2'd3: begin
                wstrb_raw = 8'hFF;
                ms_wdata  = head_q.st_data;
            end
        endcase
    end

    assign ms_valid      = head_valid_q;
    assign ms_pc         = head_q.pc;
    assign ms_alu_result = head_q.alu_result;
    assign ms_addr       = {head_q.mem_addr[XLEN-1:3], 3'b000};
    assign ms_byte_off   = off;
    assign ms_rf_we      = head_valid_q & head_q.rf_we;
    assign ms_rf_waddr   = head_q.rf_waddr;
    assign ms_mem_re     = head_valid_q & head_q.mem_re & ~suppress;
    assign ms_mem_we     = head_valid_q & head_q.mem_we & ~suppress;
    assign ms_wstrb      = (head_valid_q & head_q.mem_we & ~suppress) ? wstrb_raw : 8'h00;
    assign ms_mem_size   = head_q.mem_size;
    assign ms_ld_uns     = head_q.ld_uns;

endmodule

// File: tb/tb_ysyx_22041752_ex_ms_buf.sv
// Directed self-checking bench for the EX->MEM skid buffer.
module tb_ysyx_22041752_ex_ms_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [63:0] es_pc, es_alu_result, es_mem_addr, es_st_data;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic        es_mem_re, es_mem_we;
    logic [1:0]  es_mem_size;
    logic        es_ld_uns;
    logic        ms_valid, ms_ready;
    logic [63:0] ms_pc, ms_alu_result, ms_addr, ms_wdata;
    logic [2:0]  ms_byte_off;
    logic [7:0]  ms_wstrb;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic        ms_mem_re, ms_mem_we;
    logic [1:0]  ms_mem_size;
    logic        ms_ld_uns, ms_misalign;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22041752_ex_ms_buf #(.XLEN(64), .RF_AW(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_alu_result(es_alu_result), .es_mem_addr(es_mem_addr),
        .es_st_data(es_st_data), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
        .es_mem_re(es_mem_re), .es_mem_we(es_mem_we), .es_mem_size(es_mem_size),
        .es_ld_uns(es_ld_uns),
        .ms_valid(ms_valid), .ms_ready(ms_ready), .ms_pc(ms_pc),
        .ms_alu_result(ms_alu_result), .ms_addr(ms_addr), .ms_byte_off(ms_byte_off),
        .ms_wstrb(ms_wstrb), .ms_wdata(ms_wdata), .ms_rf_we(ms_rf_we),
        .ms_rf_waddr(ms_rf_waddr), .ms_mem_re(ms_mem_re), .ms_mem_we(ms_mem_we),
        .ms_mem_size(ms_mem_size), .ms_ld_uns(ms_ld_uns), .ms_misalign(ms_misalign)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [63:0] addr, input logic [63:0] sd,
                         input logic re, input logic we, input logic [1:0] size);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_alu_result  = pc + 64'h1000;
        es_mem_addr    = addr;
        es_st_data     = sd;
        es_mem_re      = re;
        es_mem_we      = we;
        es_mem_size    = size;
        es_rf_we       = re;
        es_rf_waddr    = 5'd7;
        es_ld_uns      = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; ms_ready = 1'b0; es_to_ms_valid = 1'b0;
        es_pc = '0; es_alu_result = '0; es_mem_addr = '0; es_st_data = '0;
        es_rf_we = 1'b0; es_rf_waddr = '0; es_mem_re = 1'b0; es_mem_we = 1'b0;
        es_mem_size = '0; es_ld_uns = 1'b0;
        tick(); tick();
        check("rst_valid", {63'd0, ms_valid}, 64'd0);
        check("rst_allowin", {63'd0, ms_allowin}, 64'd1);
        check("rst_wstrb", {56'd0, ms_wstrb}, 64'd0);
        check("rst_pc", ms_pc, 64'd0);
        check("rst_wdata", ms_wdata, 64'd0);
        reset = 1'b1;
        tick();

        // Stores with ms_ready held high: each lands in head the next cycle.
        ms_ready = 1'b1;
        offer(64'h100, 64'h8000_0005, 64'h1234_5678_9ABC_DEAB, 1'b0, 1'b1, 2'd0);
        tick();
        check("sb_valid", {63'd0, ms_valid}, 64'd1);
        check("sb_addr", ms_addr, 64'h8000_0000);
        check("sb_off", {61'd0, ms_byte_off}, 64'd5);
        check("sb_wstrb", {56'd0, ms_wstrb}, 64'h20);
        check("sb_wdata", ms_wdata, 64'hABAB_ABAB_ABAB_ABAB);
        check("sb_pc", ms_pc, 64'h100);
        offer(64'h104, 64'h8000_0004, 64'h1122_3344, 1'b0, 1'b1, 2'd2);
        tick();
        check("sw_wstrb", {56'd0, ms_wstrb}, 64'hF0);
        check("sw_wdata", ms_wdata, 64'h1122_3344_1122_3344);
        offer(64'h108, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 2'd3);
        tick();
        check("sd_wstrb", {56'd0, ms_wstrb}, 64'hFF);
        check("sd_wdata", ms_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        offer(64'h10C, 64'h8000_0006, 64'h5566, 1'b0, 1'b1, 2'd1);
        tick();
        check("sh_wstrb", {56'd0, ms_wstrb}, 64'hC0);
        check("sh_wdata", ms_wdata, 64'h5566_5566_5566_5566);
        offer(64'h110, 64'h10, 64'h0, 1'b1, 1'b0, 2'd3);
        tick();
        check("ld_wstrb", {56'd0, ms_wstrb}, 64'h00);
        check("ld_re", {63'd0, ms_mem_re}, 64'd1);
        check("ld_rfwe", {63'd0, ms_rf_we}, 64'd1);
        check("ld_waddr", {59'd0, ms_rf_waddr}, 64'd7);
        check("ld_alu", ms_alu_result, 64'h1110);
        es_to_ms_valid = 1'b0;
        tick();
        check("idle_valid", {63'd0, ms_valid}, 64'd0);
        check("idle_re", {63'd0, ms_mem_re}, 64'd0);
        check("idle_rfwe", {63'd0, ms_rf_we}, 64'd0);

        // A, B, C back to back while MEM stalls.
        ms_ready = 1'b0;
        offer(64'hA0, 64'h0, 64'h0, 1'b1, 1'b0, 2'd3);
        tick();
        check("a_pc", ms_pc, 64'hA0);
        check("a_allowin", {63'd0, ms_allowin}, 64'd1);
        offer(64'hB0, 64'h0, 64'h0, 1'b1, 1'b0, 2'd3);
        tick();
        check("b_head_pc", ms_pc, 64'hA0);
        check("b_allowin", {63'd0, ms_allowin}, 64'd0);
        offer(64'hC0, 64'h0, 64'h0, 1'b1, 1'b0, 2'd3);
        tick();
        check("c_held_pc", ms_pc, 64'hA0);
        check("c_held_allowin", {63'd0, ms_allowin}, 64'd0);
        ms_ready = 1'b1;
        tick();
        check("drain_b", ms_pc, 64'hB0);
        check("drain_b_valid", {63'd0, ms_valid}, 64'd1);
        check("drain_b_allowin", {63'd0, ms_allowin}, 64'd1);
        tick();
        check("drain_c", ms_pc, 64'hC0);
        check("drain_c_valid", {63'd0, ms_valid}, 64'd1);
        es_to_ms_valid = 1'b0;
        tick();
        check("drain_end", {63'd0, ms_valid}, 64'd0);

        // Flush with both entries full and a new instruction offered.
        ms_ready = 1'b0;
        offer(64'hD0, 64'h0, 64'h0, 1'b1, 1'b0, 2'd3);
        tick();
        offer(64'hD4, 64'h0, 64'h0, 1'b1, 1'b0, 2'd3);
        tick();
        check("pre_flush_allowin", {63'd0, ms_allowin}, 64'd0);
        flush = 1'b1;
        offer(64'hE0, 64'h0, 64'h0, 1'b1, 1'b0, 2'd3);
        tick();
        check("flush_valid", {63'd0, ms_valid}, 64'd0);
        check("flush_allowin", {63'd0, ms_allowin}, 64'd1);
        flush = 1'b0;
        es_to_ms_valid = 1'b0;
        ms_ready = 1'b1;
        tick();
        check("post_flush1", {63'd0, ms_valid}, 64'd0);
        tick();
        check("post_flush2", {63'd0, ms_valid}, 64'd0);

        // Misaligned half load and half store at offset 3.
        offer(64'hF0, 64'h8000_0003, 64'h0, 1'b1, 1'b0, 2'd1);
        tick();
`ifdef YSYX_22041752_MISALIGN_CHK_EN
        check("mis_ld_flag", {63'd0, ms_misalign}, 64'd1);
        check("mis_ld_re", {63'd0, ms_mem_re}, 64'd0);
`else
        check("mis_ld_flag", {63'd0, ms_misalign}, 64'd0);
        check("mis_ld_re", {63'd0, ms_mem_re}, 64'd1);
`endif
        offer(64'hF4, 64'h8000_0003, 64'h77, 1'b0, 1'b1, 2'd1);
        tick();
`ifdef YSYX_22041752_MISALIGN_CHK_EN
        check("mis_st_wstrb", {56'd0, ms_wstrb}, 64'h00);
        check("mis_st_we", {63'd0, ms_mem_we}, 64'd0);
`else
        check("mis_st_wstrb", {56'd0, ms_wstrb}, 64'h0C);
        check("mis_st_we", {63'd0, ms_mem_we}, 64'd1);
`endif

        // Asynchronous reset takes effect between edges.
        ms_ready = 1'b0;
        offer(64'h200, 64'h0, 64'h0, 1'b1, 1'b0, 2'd3);
        tick();
        offer(64'h204, 64'h0, 64'h0, 1'b1, 1'b0, 2'd3);
        tick();
        check("pre_rst_valid", {63'd0, ms_valid}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, ms_valid}, 64'd0);
        check("async_rst_allowin", {63'd0, ms_allowin}, 64'd1);
        check("async_rst_pc", ms_pc, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
